// File: rtl/iq_demod_core.sv
// Multi-mode AM/PM/FM demodulator around one sequential vectoring CORDIC.
// One sample in flight: accept, pre-rotate, iterate, post-process, idle.
module iq_demod_core #(
    parameter int XY_BITS    = 16,
    parameter int PH_BITS    = 16,
    parameter int ITERATIONS = 16,
    parameter int OUT_BITS   = 24
) (
    input  logic                      clk_in,
    input  logic                      RST,
    input  logic [1:0]                mode,
    input  logic [XY_BITS-1:0]        squelch,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [XY_BITS-1:0] I_in,
    input  logic signed [XY_BITS-1:0] Q_in,
    output logic                      out_valid,
    output logic [OUT_BITS-1:0]       demod_out,
    output logic [XY_BITS:0]          mag_out,
    output logic [PH_BITS-1:0]        phase_out
);

    // x/y keep two integer headroom bits for the CORDIC gain plus
    // fractional guard bits so truncation in the shifts stays below
    // one output LSB; z carries guard bits for the same reason.
    // The atan table is held at 2^32 per turn, so PH_BITS must be <= 27.
    localparam int XF       = 4;
    localparam int XW       = XY_BITS + 2 + XF;
    localparam int ZG       = 4;
    localparam int ZW       = PH_BITS + ZG;
    localparam int MAG_BITS = XY_BITS + 1;
    localparam int CW       = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;

    localparam logic [1:0] MODE_PM = 2'b01;
    localparam logic [1:0] MODE_FM = 2'b10;

    localparam logic signed [XW-1:0] X_HALF = XW'(1 << (XF - 1));
    localparam logic [ZW-1:0]        Z_HALF = ZW'(1 << (ZG - 1));
    localparam logic [ZW-1:0]        Z_PI   = {1'b1, {(ZW-1){1'b0}}};
    localparam logic [CW-1:0]        K_LAST = CW'(ITERATIONS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PREROT,
        S_ITER,
        S_POST
    } state_t;

    // atan(2^-k) as a fraction of a full turn, scaled to 2^32
    function automatic logic [31:0] atan_turn32(input int k);
        logic [31:0] v;
        case (k)
            0:       v = 32'h2000_0000;
            1:       v = 32'h12E4_051E;
            2:       v = 32'h09FB_385B;
            3:       v = 32'h0511_11D4;
            4:       v = 32'h028B_0D43;
            5:       v = 32'h0145_D7E1;
            6:       v = 32'h00A2_F61E;
            7:       v = 32'h0051_7C55;
            8:       v = 32'h0028_BE53;
            9:       v = 32'h0014_5F2F;
            10:      v = 32'h000A_2F98;
            11:      v = 32'h0005_17CC;
            12:      v = 32'h0002_8BE6;
            13:      v = 32'h0001_45F3;
            14:      v = 32'h0000_A2F9;
            15:      v = 32'h0000_517C;
            16:      v = 32'h0000_28BE;
            17:      v = 32'h0000_145F;
            18:      v = 32'h0000_0A2F;
            19:      v = 32'h0000_0517;
            20:      v = 32'h0000_028B;
            21:      v = 32'h0000_0145;
            22:      v = 32'h0000_00A2;
            23:      v = 32'h0000_0051;
            24:      v = 32'h0000_0028;
            25:      v = 32'h0000_0014;
            26:      v = 32'h0000_000A;
            27:      v = 32'h0000_0005;
            28:      v = 32'h0000_0002;
            29:      v = 32'h0000_0001;
            default: v = 32'h0000_0000;
        endcase
        return v;
    endfunction

    // round the 32-bit turn fraction down to the z register width
    function automatic logic [ZW-1:0] atan_entry(input int k);
        logic [31:0] t;
        t = atan_turn32(k) + (32'd1 << (31 - ZW));
        return t[31 -: ZW];
    endfunction

    logic [ZW-1:0] atan_tab [ITERATIONS];

    for (genvar g = 0; g < ITERATIONS; g++) begin : g_atan
        assign atan_tab[g] = atan_entry(g);
    end

    state_t                state;
    logic [CW-1:0]         k_r;
    logic signed [XW-1:0]  x_r;
    logic signed [XW-1:0]  y_r;
    logic [ZW-1:0]         z_r;
    logic [1:0]            mode_r;
    logic [XY_BITS-1:0]    squelch_r;
    logic                  zero_r;
    logic [PH_BITS-1:0]    prev_phase;
    logic                  first_flag;

    logic signed [XW-1:0]  x_sh;
    logic signed [XW-1:0]  y_sh;
    logic signed [XW-1:0]  x_nxt;
    logic signed [XW-1:0]  y_nxt;
    logic [ZW-1:0]         z_nxt;

    // one vectoring micro-rotation driving y towards zero
    always_comb begin
        x_sh = x_r >>> k_r;
        y_sh = y_r >>> k_r;
        if (y_r[XW-1]) begin
            x_nxt = x_r - y_sh;
            y_nxt = y_r + x_sh;
            z_nxt = z_r - atan_tab[k_r];
        end else begin
            x_nxt = x_r + y_sh;
            y_nxt = y_r - x_sh;
            z_nxt = z_r + atan_tab[k_r];
        end
    end

    logic signed [XW-1:0]  x_rnd;
    logic [ZW-1:0]         z_rnd;
    logic [MAG_BITS-1:0]   mag_c;
    logic [PH_BITS-1:0]    ph_c;
    logic [PH_BITS-1:0]    diff_c;
    logic                  quiet_c;
    logic [OUT_BITS-1:0]   demod_c;
    logic                  first_c;
    logic                  unused_bits;

    // final rounding, squelch and per-mode result selection
    always_comb begin
        x_rnd   = x_r + X_HALF;
        z_rnd   = z_r + Z_HALF;
        mag_c   = x_rnd[XF +: MAG_BITS];
        ph_c    = zero_r ? '0 : z_rnd[ZG +: PH_BITS];
        diff_c  = ph_c - prev_phase;
        quiet_c = (squelch_r != '0) && ({1'b0, squelch_r} > mag_c);
        demod_c = '0;
        first_c = 1'b1;
        if (quiet_c) begin
            demod_c = '0;
            first_c = 1'b1;
        end else if (mode_r == MODE_FM) begin
            demod_c = first_flag ? '0 : OUT_BITS'($signed(diff_c));
            first_c = 1'b0;
        end else if (mode_r == MODE_PM) begin
            demod_c = OUT_BITS'($signed(ph_c));
            first_c = 1'b1;
        end else begin
            demod_c = OUT_BITS'(mag_c);
            first_c = 1'b1;
        end
    end

    assign unused_bits = ^{x_rnd[XW-1], x_rnd[XF-1:0], z_rnd[ZG-1:0]};

    // sequencer, CORDIC registers and registered outputs
    always_ff @(posedge clk_in or negedge RST) begin
        if (!RST) begin
            state      <= S_IDLE;
            k_r        <= '0;
            x_r        <= '0;
            y_r        <= '0;
            z_r        <= '0;
            mode_r     <= '0;
            squelch_r  <= '0;
            zero_r     <= 1'b0;
            prev_phase <= '0;
            first_flag <= 1'b1;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            demod_out  <= '0;
            mag_out    <= '0;
            phase_out  <= '0;
        end else begin
            out_valid <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        x_r       <= {{2{I_in[XY_BITS-1]}}, I_in, {XF{1'b0}}};
                        y_r       <= {{2{Q_in[XY_BITS-1]}}, Q_in, {XF{1'b0}}};
                        mode_r    <= mode;
                        squelch_r <= squelch;
                        zero_r    <= (I_in == '0) && (Q_in == '0);
                        in_ready  <= 1'b0;
                        state     <= S_PREROT;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                S_PREROT: begin
                    if (x_r[XW-1]) begin
                        x_r <= -x_r;
                        y_r <= -y_r;
                        z_r <= Z_PI;
                    end else begin
                        z_r <= '0;
                    end
                    k_r   <= '0;
                    state <= S_ITER;
                end
                S_ITER: begin
                    x_r <= x_nxt;
                    y_r <= y_nxt;
                    z_r <= z_nxt;
                    k_r <= k_r + 1'b1;
                    if (k_r == K_LAST) begin
                        state <= S_POST;
                    end
                end
                S_POST: begin
                    mag_out    <= mag_c;
                    phase_out  <= ph_c;
                    demod_out  <= demod_c;
                    prev_phase <= ph_c;
                    first_flag <= first_c;
                    out_valid  <= 1'b1;
                    in_ready   <= 1'b1;
                    state      <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
